// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: four-digit multiplexed display scanner feeding a hex-to-7-seg
// decoder. Holds a shadow copy of the value/point/blank masks, steps through
// the digits once per SCAN_PERIOD clocks, and inserts one dark cycle at every
// digit switch so the previous digit's segments never ghost onto the next one.
//
// Optional feature: define DISP_SCAN_LZB_EN to enable leading-zero blanking
// (digits 3..1 go dark while they and every digit to their left are zero).
module disp_scan_ctrl #(
    parameter int SCAN_PERIOD = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] hexs,
    input  logic [3:0]  points,
    input  logic [3:0]  les,
    output logic [3:0]  D,
    output logic        LE,
    output logic        point,
    output logic [3:0]  AN,
    output logic        frame_done
);

    localparam int CNT_W = (SCAN_PERIOD > 2) ? $clog2(SCAN_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_PERIOD - 1);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [15:0]      hex_q;
    logic [3:0]       pt_q;
    logic [3:0]       le_q;

    logic [3:0]       lzb_v;
    logic [3:0]       nib;
    logic             le_lit;
    logic             slot_end;

`ifdef DISP_SCAN_LZB_EN
    // Digit k is a leading zero when nibbles k..3 are all zero; digit 0 always shows.
    assign lzb_v = {hex_q[15:12] == 4'h0,
                    hex_q[15:8]  == 8'h0,
                    hex_q[15:4]  == 12'h0,
                    1'b0};
`else
    assign lzb_v = 4'b0000;
`endif

    // Next-output terms for the digit currently selected by idx.
    always_comb begin
        nib      = hex_q[4*idx +: 4];
        le_lit   = le_q[idx] | lzb_v[idx];
        slot_end = (cnt == CNT_MAX);
    end

    // Prescaler, digit index and shadow registers; a load never disturbs scanning.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            idx   <= 2'd0;
            hex_q <= 16'h0000;
            pt_q  <= 4'h0;
            le_q  <= 4'hF;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (load) begin
                hex_q <= hexs;
                pt_q  <= points;
                le_q  <= les;
            end
        end
    end

    // Registered outputs from pre-edge state; cnt==0 is the dark dead cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            D          <= 4'h0;
            LE         <= 1'b1;
            point      <= 1'b0;
            AN         <= 4'b1111;
            frame_done <= 1'b0;
        end else begin
            // D already carries the upcoming nibble during the dead cycle so the
            // decoder input is settled when the anode turns on.
            D          <= nib;
            frame_done <= slot_end && (idx == 2'd3);
            if (cnt == '0) begin
                AN    <= 4'b1111;
                LE    <= 1'b1;
                point <= 1'b0;
            end else begin
                AN    <= ~(4'b0001 << idx);
                LE    <= le_lit;
                point <= pt_q[idx] & ~le_lit;
            end
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl with SCAN_PERIOD=4: a vector table,
// hand-written corner sequences, and a randomized run against a reference model.
module tb_disp_scan_ctrl;

    localparam int SP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] hexs;
    logic [3:0]  points;
    logic [3:0]  les;
    logic [3:0]  D;
    logic        LE;
    logic        point;
    logic [3:0]  AN;
    logic        frame_done;

    disp_scan_ctrl #(.SCAN_PERIOD(SP)) dut (
        .clk(clk), .rst(rst), .load(load), .hexs(hexs), .points(points), .les(les),
        .D(D), .LE(LE), .point(point), .AN(AN), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: position in the frame since reset release plus shadow copy.
    int          m_p;
    logic [15:0] m_hex;
    logic [3:0]  m_pt;
    logic [3:0]  m_le;
    int          last_p;
    bit          last_rst;

    function automatic logic m_lzb(int d, logic [15:0] h);
`ifdef DISP_SCAN_LZB_EN
        logic [15:0] s;
        s = h >> (4 * d);
        return (d != 0) && (s == 16'h0000);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock edge with the given inputs, checked against the model.
    task automatic tick(input logic r, input logic ld, input logic [15:0] h,
                        input logic [3:0] pts, input logic [3:0] l);
        logic [3:0] e_d, e_an;
        logic e_le, e_pt, e_fd;
        bit chk_d;
        int c, d;
        rst = r; load = ld; hexs = h; points = pts; les = l;
        @(posedge clk);
        #1;
        last_p   = m_p;
        last_rst = r;
        chk_d = 1;
        if (r) begin
            e_d = 4'h0; e_le = 1'b1; e_pt = 1'b0; e_an = 4'hF; e_fd = 1'b0;
        end else begin
            c = m_p % SP;
            d = (m_p / SP) % 4;
            e_d  = m_hex[4*d +: 4];
            e_fd = (c == SP - 1) && (d == 3);
            if (c == 0) begin
                e_an = 4'hF; e_le = 1'b1; e_pt = 1'b0; chk_d = 0;
            end else begin
                e_an = 4'hF ^ (4'b0001 << d);
                e_le = m_le[d] | m_lzb(d, m_hex);
                e_pt = m_pt[d] & ~e_le;
            end
        end
        chk("model", {21'd0, (chk_d ? D : 4'h0), LE, point, AN, frame_done},
                     {21'd0, (chk_d ? e_d : 4'h0), e_le, e_pt, e_an, e_fd});
        if (r) begin
            m_p = 0; m_hex = 16'h0; m_pt = 4'h0; m_le = 4'hF;
        end else begin
            m_p = (m_p + 1) % (4 * SP);
            if (ld) begin
                m_hex = h; m_pt = pts; m_le = l;
            end
        end
        load = 1'b0;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    endtask

    // Advance until the model's next pre-edge position equals pos.
    task automatic goto_pos(input int pos);
        int guard = 0;
        while (m_p != pos && guard < 4 * SP + 2) begin
            idle();
            guard++;
        end
        if (m_p != pos) begin
            n_cmp++; n_fail++;
            $display("FAIL goto_pos: got %0d expected %0d", m_p, pos);
        end
    endtask

    typedef struct {
        logic [15:0] h;
        logic [3:0]  pts;
        logic [3:0]  l;
        logic [3:0]  exp_le;
        logic [3:0]  exp_pt;
        string       name;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int cnt_fd;
        int c, d;
        bit r, ld;

        vecs[0] = '{16'h12AF, 4'b0100, 4'b0000, 4'b0000, 4'b0100, "basic"};
        vecs[1] = '{16'h12AF, 4'b1111, 4'b1001, 4'b1001, 4'b0110, "blank"};
`ifdef DISP_SCAN_LZB_EN
        vecs[2] = '{16'h0030, 4'b0000, 4'b0000, 4'b1100, 4'b0000, "lzb"};
        vecs[3] = '{16'h0030, 4'b1111, 4'b0000, 4'b1100, 4'b0011, "lzb_pt"};
        vecs[4] = '{16'h0000, 4'b1111, 4'b0000, 4'b1110, 4'b0001, "lzb_zero"};
`else
        vecs[2] = '{16'h0030, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "lzb"};
        vecs[3] = '{16'h0030, 4'b1111, 4'b0000, 4'b0000, 4'b1111, "lzb_pt"};
        vecs[4] = '{16'h0000, 4'b1111, 4'b0000, 4'b0000, 4'b1111, "lzb_zero"};
`endif

        m_p = 0; m_hex = 16'h0; m_pt = 4'h0; m_le = 4'hF;
        rst = 1'b1; load = 1'b0; hexs = 16'h0; points = 4'h0; les = 4'h0;

        // Reset held 3 cycles, explicit reset-value check.
        do_reset(3);
        chk("reset_out", {D, LE, point, AN, frame_done}, {4'h0, 1'b1, 1'b0, 4'hF, 1'b0});

        // Blank until first load; first frame_done 16 edges after release.
        cnt_fd = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            cnt_fd++;
            chk("blank_after_reset", {31'd0, LE}, 32'd1);
            if (frame_done) break;
        end
        chk("first_frame_done", cnt_fd, 4 * SP);

        // Table vectors: load at the frame-end edge, then check one full frame.
        foreach (vecs[v]) begin
            goto_pos(4 * SP - 1);
            tick(1'b0, 1'b1, vecs[v].h, vecs[v].pts, vecs[v].l);
            for (int i = 0; i < 4 * SP; i++) begin
                idle();
                c = last_p % SP;
                d = (last_p / SP) % 4;
                if (c != 0)
                    chk(vecs[v].name, {21'd0, D, LE, point, AN, 1'b0},
                        {21'd0, vecs[v].h[4*d +: 4], vecs[v].exp_le[d], vecs[v].exp_pt[d],
                         4'hF ^ (4'b0001 << d), 1'b0});
                else
                    chk({vecs[v].name, "_dead"}, {28'd0, AN}, 32'hF);
            end
        end

        // Mid-slot load at cnt=2 of digit 1.
        goto_pos(4 * SP - 1);
        tick(1'b0, 1'b1, 16'h0000, 4'h0, 4'h0);
        goto_pos(SP + 2);
        tick(1'b0, 1'b1, 16'h5555, 4'h0, 4'h0);
        chk("midload_old", {24'd0, D, AN}, {24'd0, 4'h0, 4'b1101});
        idle();
        chk("midload_new", {24'd0, D, AN}, {24'd0, 4'h5, 4'b1101});
        chk("midload_pos", last_p, SP + 3);

        // Reset mid-frame at idx=2, cnt=2.
        goto_pos(2 * SP + 2);
        tick(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        chk("midrst_out", {D, LE, point, AN, frame_done}, {4'h0, 1'b1, 1'b0, 4'hF, 1'b0});
        idle();
        chk("midrst_dead", {27'd0, LE, AN}, {27'd0, 1'b1, 4'hF});
        idle();
        chk("midrst_digit0_blank", {27'd0, LE, AN}, {27'd0, 1'b1, 4'b1110});

        // Randomized run with occasional loads and resets.
        for (int i = 0; i < 800; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            ld = ($urandom_range(0, 7) == 0);
            tick(r, ld, 16'($urandom), 4'($urandom), 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
